// File: rtl/elink_trig_scrubber_multi.sv
// Multi-channel trigger e-link scrubber: per-channel last word, word/parity-error
// counters and stale flag, read over a pipelined Wishbone slave, cleared by a stalling sweep.
module elink_trig_scrubber_multi #(
  parameter int  N_CH      = 4,
  parameter int  DATA_W    = 12,
  parameter int  CNT_W     = 12,
  parameter int  WB_W      = 12,
  parameter int  STALE_CYC = 1023,
  localparam int ADDR_W    = $clog2(N_CH) + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] i_trig_data,
  input  logic [N_CH-1:0]        i_trig_valid,
  input  logic                   i_clear_all,
  input  logic [ADDR_W-1:0]      i_wb_addr,
  input  logic                   i_wb_stb,
  output logic [WB_W-1:0]        o_wb_data,
  output logic                   o_wb_ack,
  output logic                   o_wb_stall
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(STALE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STALE_CYC);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [WB_W-1:0]   reg_val [N_CH][4];
  logic [ADDR_W-1:0] ch_full;
  logic [WB_W-1:0]   rd_val;
  logic              accept;

  // ---------------- clear-all sweep FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a signal unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (i_clear_all) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == CH_W'(N_CH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // ---------------- per-channel trackers ----------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [CH_W-1:0] MY_IDX = CH_W'(c);

    logic [DATA_W-1:0] word;
    logic              clr;
    logic [DATA_W-1:0] last_word_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [TMR_W-1:0]  tmr_q;

    assign word = i_trig_data[c*DATA_W +: DATA_W];
    // A sweep clear on this channel takes priority over a coincident valid word.
    assign clr  = (state_q == SWEEP) && (idx_q == MY_IDX);

    // NOTE: this per-channel state is plain flops, not RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_word_q <= '0;
        word_cnt_q  <= '0;
        err_cnt_q   <= '0;
        tmr_q       <= '0;
      end else if (clr) begin
        last_word_q <= '0;
        word_cnt_q  <= '0;
        err_cnt_q   <= '0;
        tmr_q       <= '0;
      end else if (i_trig_valid[c]) begin
        last_word_q <= word;
        if (word_cnt_q != CNT_MAX) word_cnt_q <= word_cnt_q + 1'b1;
        if ((^word) && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
        tmr_q <= '0;
      end else if (tmr_q != TMR_MAX) begin
        tmr_q <= tmr_q + 1'b1;
      end
    end

    assign reg_val[c][0] = WB_W'(last_word_q);
    assign reg_val[c][1] = WB_W'(word_cnt_q);
    assign reg_val[c][2] = WB_W'(err_cnt_q);
    assign reg_val[c][3] = WB_W'(tmr_q == TMR_MAX);
  end

  // ---------------- Wishbone read slave ----------------
  assign ch_full    = i_wb_addr >> 2;
  assign o_wb_stall = (state_q == SWEEP);
  assign accept     = i_wb_stb && !o_wb_stall;

  always_comb begin
    rd_val = '0;
    if (ch_full < ADDR_W'(N_CH)) rd_val = reg_val[CH_W'(ch_full)][i_wb_addr[1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb_data <= '0;
      o_wb_ack  <= 1'b0;
    end else begin
      o_wb_ack <= accept;
      if (accept) o_wb_data <= rd_val;
    end
  end
endmodule

// File: tb/tb_elink_trig_scrubber_multi.sv
// Directed + randomized bench for elink_trig_scrubber_multi, checked against a
// cycle-level behavioural model of channel statistics and the read handshake.
module tb_elink_trig_scrubber_multi;
  localparam int N_CH      = 4;
  localparam int DATA_W    = 12;
  localparam int CNT_W     = 4;
  localparam int WB_W      = 12;
  localparam int STALE_CYC = 15;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_CH*DATA_W-1:0] trig_data = '0;
  logic [N_CH-1:0]        trig_valid = '0;
  logic                   clear_all = 1'b0;
  logic [3:0]             wb_addr = '0;
  logic                   wb_stb = 1'b0;
  logic [WB_W-1:0]        wb_data;
  logic                   wb_ack;
  logic                   wb_stall;

  elink_trig_scrubber_multi #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .WB_W(WB_W), .STALE_CYC(STALE_CYC)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_trig_data(trig_data),
    .i_trig_valid(trig_valid),
    .i_clear_all(clear_all),
    .i_wb_addr(wb_addr),
    .i_wb_stb(wb_stb),
    .o_wb_data(wb_data),
    .o_wb_ack(wb_ack),
    .o_wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  // Reference model: statistics per channel, cycles since last valid, remaining sweep cycles.
  int              m_last [N_CH];
  int              m_wc   [N_CH];
  int              m_ec   [N_CH];
  int              m_idle [N_CH];
  int              sweep_left = 0;
  logic [WB_W-1:0] exp_data = '0;
  logic            exp_ack = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_last[c] = 0; m_wc[c] = 0; m_ec[c] = 0; m_idle[c] = 0;
    end
    sweep_left = 0;
    exp_data   = '0;
    exp_ack    = 1'b0;
  endtask

  function automatic int model_read(input int a);
    int ch, r;
    ch = a / 4;
    r  = a % 4;
    if (ch >= N_CH) return 0;
    case (r)
      0:       return m_last[ch];
      1:       return m_wc[ch];
      2:       return m_ec[ch];
      default: return (m_idle[ch] >= STALE_CYC) ? 1 : 0;
    endcase
  endfunction

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic tick();
    logic              acc;
    int                rd_v;
    logic [DATA_W-1:0] w;
    acc  = wb_stb && (sweep_left == 0);
    rd_v = model_read(int'(wb_addr));
    for (int c = 0; c < N_CH; c++) begin
      w = trig_data[c*DATA_W +: DATA_W];
      if (sweep_left > 0 && c == N_CH - sweep_left) begin
        m_last[c] = 0; m_wc[c] = 0; m_ec[c] = 0; m_idle[c] = 0;
      end else if (trig_valid[c]) begin
        m_last[c] = int'(w);
        m_wc[c]   = (m_wc[c] < CNT_MAX) ? m_wc[c] + 1 : CNT_MAX;
        if ($countones(w) % 2 == 1) m_ec[c] = (m_ec[c] < CNT_MAX) ? m_ec[c] + 1 : CNT_MAX;
        m_idle[c] = 0;
      end else if (m_idle[c] < STALE_CYC) begin
        m_idle[c]++;
      end
    end
    if (sweep_left > 0) sweep_left--;
    else if (clear_all) sweep_left = N_CH;
    if (acc) exp_data = WB_W'(rd_v);
    exp_ack = acc;
    @(posedge clk);
    #1;
    chk("ack",   32'(wb_ack),   32'(exp_ack));
    chk("stall", 32'(wb_stall), 32'(sweep_left > 0));
    chk("data",  32'(wb_data),  32'(exp_data));
  endtask

  task automatic rd_expect(input string tag, input logic [3:0] a, input int e);
    wb_stb  = 1'b1;
    wb_addr = a;
    tick();
    wb_stb  = 1'b0;
    chk(tag, 32'(wb_data), 32'(e));
  endtask

  initial begin
    int                stall_n;
    logic [DATA_W-1:0] w;

    model_reset();

    // Reset held with activity on every input: outputs stay quiet.
    for (int i = 0; i < 6; i++) begin
      trig_valid = 4'($urandom);
      trig_data  = {16'($urandom), 32'($urandom)};
      wb_stb     = 1'b1;
      wb_addr    = 4'($urandom);
      @(posedge clk);
      #1;
      chk("rst_ack",   32'(wb_ack),   32'd0);
      chk("rst_stall", 32'(wb_stall), 32'd0);
      chk("rst_data",  32'(wb_data),  32'd0);
    end
    trig_valid = '0;
    wb_stb     = 1'b0;
    rst_n      = 1'b1;
    rd_expect("post_rst_last2", 4'h8, 0);
    rd_expect("post_rst_wc0",   4'h1, 0);

    // Count and parity on channel 2.
    trig_valid = 4'b0100;
    trig_data[2*DATA_W +: DATA_W] = 12'h003; tick();
    trig_data[2*DATA_W +: DATA_W] = 12'h001; tick();
    trig_data[2*DATA_W +: DATA_W] = 12'h7FF; tick();
    trig_valid = '0;
    rd_expect("ch2_wc",   4'h9, 3);
    rd_expect("ch2_ec",   4'hA, 2);
    rd_expect("ch2_last", 4'h8, 12'h7FF);

    // Back-to-back reads: one ack per accept, in order.
    wb_stb = 1'b1;
    wb_addr = 4'h1; tick(); chk("b2b_ack0", 32'(wb_ack), 32'd1); chk("b2b_d0", 32'(wb_data), 32'd0);
    wb_addr = 4'h5; tick(); chk("b2b_ack1", 32'(wb_ack), 32'd1); chk("b2b_d1", 32'(wb_data), 32'd0);
    wb_addr = 4'h9; tick(); chk("b2b_ack2", 32'(wb_ack), 32'd1); chk("b2b_d2", 32'(wb_data), 32'd3);
    wb_stb = 1'b0;
    tick();
    chk("b2b_noack", 32'(wb_ack), 32'd0);
    chk("b2b_hold",  32'(wb_data), 32'd3);

    // Stale boundary on channel 1.
    trig_valid = 4'b0010;
    trig_data[1*DATA_W +: DATA_W] = 12'h5A5;
    tick();
    trig_valid = '0;
    repeat (14) tick();
    rd_expect("stale_at_14", 4'h7, 0);
    rd_expect("stale_at_15", 4'h7, 1);
    trig_valid = 4'b0010;
    tick();
    trig_valid = '0;
    rd_expect("stale_cleared", 4'h7, 0);

    // Saturation: 20 odd-parity words on channel 0.
    for (int i = 0; i < 20; i++) begin
      w = DATA_W'($urandom);
      if ($countones(w) % 2 == 0) w[0] = ~w[0];
      trig_data[0 +: DATA_W] = w;
      trig_valid = 4'b0001;
      tick();
    end
    trig_valid = '0;
    rd_expect("sat_wc", 4'h1, CNT_MAX);
    rd_expect("sat_ec", 4'h2, CNT_MAX);

    // Clear-all sweep with bus requests, a repeated clear, and valids racing the sweep.
    trig_valid = 4'hF;
    repeat (3) begin
      trig_data = {16'($urandom), 32'($urandom)};
      tick();
    end
    trig_valid = '0;
    clear_all  = 1'b1;
    tick();
    clear_all  = 1'b0;
    stall_n    = int'(wb_stall);
    wb_stb     = 1'b1;
    wb_addr    = 4'h1;
    for (int k = 0; k < 4; k++) begin
      trig_data  = {16'($urandom), 32'($urandom)};
      trig_valid = (k == 1) ? 4'b0001 : (k == 3) ? 4'b1000 : 4'b0000;
      clear_all  = (k == 2);
      tick();
      chk("sweep_noack", 32'(wb_ack), 32'd0);
      stall_n += int'(wb_stall);
    end
    wb_stb     = 1'b0;
    trig_valid = '0;
    clear_all  = 1'b0;
    chk("sweep_len", 32'(stall_n), 32'd4);
    rd_expect("sweep_ch3_wc", 4'hD, 0);
    rd_expect("sweep_ch0_wc", 4'h1, 1);
    for (int a = 4; a < 16; a++) rd_expect("sweep_zero", 4'(a), 0);

    // Randomized traffic: dense valids, then sparse valids to exercise staleness.
    for (int i = 0; i < 400; i++) begin
      trig_data = {16'($urandom), 32'($urandom)};
      for (int c = 0; c < N_CH; c++)
        trig_valid[c] = (i < 200) ? 1'($urandom) : ($urandom_range(15) == 0);
      clear_all = ($urandom_range(39) == 0);
      wb_stb    = 1'($urandom);
      wb_addr   = 4'($urandom);
      tick();
    end
    trig_valid = '0;
    clear_all  = 1'b0;
    wb_stb     = 1'b0;
    tick();

    // Reset in the middle of a sweep aborts it and zeroes everything.
    trig_valid = 4'hF;
    tick();
    trig_valid = '0;
    clear_all  = 1'b1;
    tick();
    clear_all  = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_stall", 32'(wb_stall), 32'd0);
    chk("midrst_ack",   32'(wb_ack),   32'd0);
    chk("midrst_data",  32'(wb_data),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_expect("midrst_ch3_wc", 4'hD, 0);
    rd_expect("midrst_ch3_last", 4'hC, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
